// File: rtl/alu_word_seq_if.sv
// alu_word_seq_if
// Bundles the three buses of the 16-bit word sequencer:
//   req_*  : request handshake (op, operands, carry, decimal flags, word/byte)
//   alu_*  : byte pass issued to the shared 8-bit alu_unit and its results
//   rsp_*  : registered 16-bit result with C/V/Z/N flags and handshake
// slave  : sequencer side (alu_word_seq)
// master : requester plus alu_unit side
interface alu_word_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_c;
  logic        req_dec_add;
  logic        req_dec_sub;
  logic        req_word;

  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_c_in;
  logic        alu_dec_add;
  logic        alu_dec_sub;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        alu_overflow;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_c;
  logic        rsp_v;
  logic        rsp_z;
  logic        rsp_n;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, req_dec_add, req_dec_sub, req_word,
    output req_ready,
    output alu_a, alu_b, alu_op, alu_c_in, alu_dec_add, alu_dec_sub,
    input  alu_out, alu_carry, alu_overflow,
    output rsp_valid, rsp_result, rsp_c, rsp_v, rsp_z, rsp_n,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, req_dec_add, req_dec_sub, req_word,
    input  req_ready,
    input  alu_a, alu_b, alu_op, alu_c_in, alu_dec_add, alu_dec_sub,
    output alu_out, alu_carry, alu_overflow,
    input  rsp_valid, rsp_result, rsp_c, rsp_v, rsp_z, rsp_n,
    output rsp_ready
  );
endinterface

// File: rtl/alu_word_seq.sv
// alu_word_seq
// Runs a 16-bit operation as one or two byte passes through the shared
// combinational 8-bit alu_unit, chaining carry between passes, and returns a
// registered 16-bit result with C/V/Z/N flags.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : alu_word_seq_if.slave (req_*, alu_*, rsp_* buses)
// Op codes (kALU_*): ORA=0 AND=1 EOR=2 ADC=3 SBC=4 SHL=5 SHR=6 ASR=7.
module alu_word_seq (
  input logic           clk,
  input logic           reset_n,
  alu_word_seq_if.slave bus
);

  localparam logic [2:0] K_ALU_ORA = 3'd0;
  localparam logic [2:0] K_ALU_AND = 3'd1;
  localparam logic [2:0] K_ALU_ADC = 3'd3;
  localparam logic [2:0] K_ALU_SBC = 3'd4;
  localparam logic [2:0] K_ALU_SHR = 3'd6;
  localparam logic [2:0] K_ALU_ASR = 3'd7;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t      state_q, state_d;

  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;
  logic        c_q, dec_add_q, dec_sub_q, word_q;
  logic [7:0]  p1_out_q;
  logic        p1_carry_q;

  logic [15:0] result_q;
  logic        c_flag_q, v_flag_q, z_flag_q, n_flag_q;

  logic        accept, capture_rsp;
  logic        hi_first, is_addsub, dec_ok;
  logic [15:0] result_d;
  logic        c_d, v_d, z_d, n_d;

  assign accept      = (state_q == IDLE) && bus.req_valid;
  // A byte op finishes at the end of PASS1; a word op at the end of PASS2.
  assign capture_rsp = ((state_q == PASS1) && !word_q) || (state_q == PASS2);
  // Right shifts must walk from the high byte down so the shifted-out bit
  // of the high byte becomes the carry into the low byte.
  assign hi_first    = word_q && ((op_q == K_ALU_SHR) || (op_q == K_ALU_ASR));
  assign is_addsub   = (op_q == K_ALU_ADC) || (op_q == K_ALU_SBC);
  assign dec_ok      = is_addsub && !(dec_add_q && dec_sub_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = PASS1;
      PASS1:   state_d = word_q ? PASS2 : DONE;
      PASS2:   state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);

  always_comb begin
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_op      = K_ALU_ORA;
    bus.alu_c_in    = 1'b0;
    bus.alu_dec_add = 1'b0;
    bus.alu_dec_sub = 1'b0;
    if (state_q == PASS1) begin
      bus.alu_a       = hi_first ? a_q[15:8] : a_q[7:0];
      bus.alu_b       = hi_first ? b_q[15:8] : b_q[7:0];
      bus.alu_op      = op_q;
      bus.alu_c_in    = c_q;
      bus.alu_dec_add = dec_ok && dec_add_q;
      bus.alu_dec_sub = dec_ok && dec_sub_q;
    end else if (state_q == PASS2) begin
      bus.alu_a       = hi_first ? a_q[7:0] : a_q[15:8];
      bus.alu_b       = hi_first ? b_q[7:0] : b_q[15:8];
      // Low byte of a right shift is always a logical shift fed by the carry.
      bus.alu_op      = hi_first ? K_ALU_SHR : op_q;
      bus.alu_c_in    = p1_carry_q;
      bus.alu_dec_add = dec_ok && dec_add_q;
      bus.alu_dec_sub = dec_ok && dec_sub_q;
    end
  end

  always_comb begin
    if (state_q == PASS1) begin
      result_d = {8'h00, bus.alu_out};
      c_d      = bus.alu_carry;
    end else begin
      result_d = hi_first ? {p1_out_q, bus.alu_out} : {bus.alu_out, p1_out_q};
      // AND reports "result nonzero" in carry, so combine both bytes.
      c_d      = (op_q == K_ALU_AND) ? (p1_carry_q | bus.alu_carry) : bus.alu_carry;
    end
    // ADC/SBC never run high-first, so the finishing pass is the high byte.
    v_d = is_addsub && bus.alu_overflow;
    z_d = (result_d == 16'h0000);
    n_d = word_q ? result_d[15] : result_d[7];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= K_ALU_ORA;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      dec_add_q  <= 1'b0;
      dec_sub_q  <= 1'b0;
      word_q     <= 1'b0;
      p1_out_q   <= '0;
      p1_carry_q <= 1'b0;
      result_q   <= '0;
      c_flag_q   <= 1'b0;
      v_flag_q   <= 1'b0;
      z_flag_q   <= 1'b0;
      n_flag_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= bus.req_op;
        a_q       <= bus.req_a;
        b_q       <= bus.req_b;
        c_q       <= bus.req_c;
        dec_add_q <= bus.req_dec_add;
        dec_sub_q <= bus.req_dec_sub;
        word_q    <= bus.req_word;
      end
      if (state_q == PASS1) begin
        p1_out_q   <= bus.alu_out;
        p1_carry_q <= bus.alu_carry;
      end
      if (capture_rsp) begin
        result_q <= result_d;
        c_flag_q <= c_d;
        v_flag_q <= v_d;
        z_flag_q <= z_d;
        n_flag_q <= n_d;
      end
    end
  end

  assign bus.rsp_result = result_q;
  assign bus.rsp_c      = c_flag_q;
  assign bus.rsp_v      = v_flag_q;
  assign bus.rsp_z      = z_flag_q;
  assign bus.rsp_n      = n_flag_q;

endmodule

// File: tb/tb_alu_word_seq.sv
// tb_alu_word_seq
// Drives alu_word_seq through its interface with a behavioural 8-bit
// alu_unit attached, and compares responses against word-level arithmetic.
module tb_alu_word_seq;

  localparam logic [2:0] OP_ORA = 3'd0, OP_AND = 3'd1, OP_EOR = 3'd2, OP_ADC = 3'd3;
  localparam logic [2:0] OP_SBC = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_ASR = 3'd7;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_word_seq_if bus ();

  alu_word_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 8-bit alu_unit model: {overflow, carry, out}. Logic/shift ops drive a
  // non-zero overflow so the sequencer has to mask it.
  function automatic logic [9:0] alu8(input logic [2:0] op, input logic [7:0] a, b,
                                      input logic cin, da, ds);
    logic [8:0] s;
    logic [7:0] o;
    logic       co, vo, hc;
    int         lo, hi;
    o = 8'h00; co = 1'b0; vo = a[6];
    s = {1'b0, a} + {1'b0, b} + {8'h00, cin};
    case (op)
      OP_ORA: begin o = a | b; co = cin; end
      OP_AND: begin o = a & b; co = |(a & b); end
      OP_EOR: begin o = a ^ b; co = cin; end
      OP_ADC, OP_SBC: begin
        vo = (a[7] == b[7]) && (s[7] != a[7]);
        lo = int'(a[3:0]) + int'(b[3:0]) + int'(cin);
        if (da) begin
          if (lo > 9) lo = lo + 6;
          hc = (lo > 15);
          hi = int'(a[7:4]) + int'(b[7:4]) + int'(hc);
          if (hi > 9) hi = hi + 6;
          co = (hi > 15);
          o  = {hi[3:0], lo[3:0]};
        end else if (ds) begin
          hc = (lo > 15);
          if (!hc) lo = lo - 6;
          hi = int'(a[7:4]) + int'(b[7:4]) + int'(hc);
          co = (hi > 15);
          if (!co) hi = hi - 6;
          o  = {hi[3:0], lo[3:0]};
        end else begin
          o = s[7:0]; co = s[8];
        end
      end
      OP_SHL: begin o = {a[6:0], cin}; co = a[7]; end
      OP_SHR: begin o = {cin, a[7:1]}; co = a[0]; end
      default: begin o = {a[7], a[7:1]}; co = a[0]; end
    endcase
    return {vo, co, o};
  endfunction

  assign {bus.alu_overflow, bus.alu_carry, bus.alu_out} =
    alu8(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_c_in, bus.alu_dec_add, bus.alu_dec_sub);

  // Word/byte reference computed directly from the operation definitions.
  function automatic void ref_op(input logic [2:0] op, input logic [15:0] a, b,
                                 input logic c, word,
                                 output logic [15:0] res, output logic [3:0] cvzn);
    logic [31:0] m, aa, bb, s;
    int          top;
    logic        cf, vf;
    m   = word ? 32'h0000FFFF : 32'h000000FF;
    top = word ? 15 : 7;
    aa  = {16'h0, a} & m;
    bb  = {16'h0, b} & m;
    cf  = 1'b0; vf = 1'b0;
    case (op)
      OP_ADC, OP_SBC: begin
        s  = aa + bb + {31'b0, c};
        cf = s[top+1];
        vf = (aa[top] == bb[top]) && (s[top] != aa[top]);
      end
      OP_ORA: begin s = aa | bb; cf = c; end
      OP_EOR: begin s = aa ^ bb; cf = c; end
      OP_AND: begin s = aa & bb; cf = (s != 0); end
      OP_SHL: begin s = (aa << 1) | {31'b0, c}; cf = aa[top]; end
      OP_SHR: begin s = (aa >> 1) | ({31'b0, c} << top); cf = aa[0]; end
      default: begin s = (aa >> 1) | ({31'b0, aa[top]} << top); cf = aa[0]; end
    endcase
    s    = s & m;
    res  = s[15:0];
    cvzn = {cf, vf, (s == 0), s[top]};
  endfunction

  int unsigned n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  logic [7:0] cap_a [0:8];
  logic [2:0] cap_op [0:8];
  logic       cap_cin [0:8];

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, b,
                        input logic c, da, ds, word,
                        output logic [15:0] res, output logic [3:0] cvzn, output int lat);
    @(negedge clk);
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_c = c;
    bus.req_dec_add = da; bus.req_dec_sub = ds; bus.req_word = word;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus: the in-flight op must not see these.
    bus.req_valid = 1'b0;
    bus.req_op = 3'($urandom); bus.req_a = 16'($urandom); bus.req_b = 16'($urandom);
    bus.req_c = 1'($urandom); bus.req_dec_add = 1'($urandom);
    bus.req_dec_sub = 1'($urandom); bus.req_word = 1'($urandom);
    lat = 0;
    while (!bus.rsp_valid && lat < 8) begin
      cap_a[lat] = bus.alu_a; cap_op[lat] = bus.alu_op; cap_cin[lat] = bus.alu_c_in;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    res  = bus.rsp_result;
    cvzn = {bus.rsp_c, bus.rsp_v, bus.rsp_z, bus.rsp_n};
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        c, da, ds, word;
    logic [15:0] res;
    logic [3:0]  cvzn;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [15:0] res, snap, eres;
    logic [3:0]  cvzn, ecvzn, snapf;
    int          lat, t;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        c, w;

    //             op      a        b        c  da ds w   res      CVZN     lat
    vecs[0]  = '{OP_ADC, 16'h12FF, 16'h0001, 0, 0, 0, 1, 16'h1300, 4'b0000, 2};
    vecs[1]  = '{OP_ADC, 16'h0999, 16'h0001, 0, 1, 0, 1, 16'h1000, 4'b0000, 2};
    vecs[2]  = '{OP_ADC, 16'h0999, 16'h0001, 0, 1, 1, 1, 16'h099A, 4'b0000, 2};
    vecs[3]  = '{OP_SBC, 16'h1000, 16'hFFFE, 1, 0, 0, 1, 16'h0FFF, 4'b1000, 2};
    vecs[4]  = '{OP_ASR, 16'h8001, 16'h0000, 0, 0, 0, 1, 16'hC000, 4'b1001, 2};
    vecs[5]  = '{OP_SHL, 16'h8080, 16'h0000, 0, 0, 0, 1, 16'h0100, 4'b1000, 2};
    vecs[6]  = '{OP_AND, 16'h12F0, 16'h340F, 0, 0, 0, 0, 16'h0000, 4'b0010, 1};
    vecs[7]  = '{OP_SHR, 16'h0003, 16'h0000, 1, 0, 0, 1, 16'h8001, 4'b1001, 2};
    vecs[8]  = '{OP_SBC, 16'h0010, 16'h00FE, 1, 0, 1, 0, 16'h0009, 4'b1000, 1};
    vecs[9]  = '{OP_ADC, 16'h7FFF, 16'h0001, 0, 0, 0, 1, 16'h8000, 4'b0101, 2};
    vecs[10] = '{OP_EOR, 16'hFFFF, 16'hFFFF, 1, 0, 0, 1, 16'h0000, 4'b1010, 2};
    vecs[11] = '{OP_AND, 16'h0001, 16'h0001, 0, 0, 0, 1, 16'h0001, 4'b1000, 2};
    vecs[12] = '{OP_ORA, 16'h5500, 16'h0080, 1, 0, 0, 0, 16'h0080, 4'b1001, 1};
    vecs[13] = '{OP_ASR, 16'h0081, 16'h0000, 0, 0, 0, 0, 16'h00C0, 4'b1001, 1};

    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_c = 1'b0;
    bus.req_dec_add = 1'b0; bus.req_dec_sub = 1'b0; bus.req_word = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("reset_rsp_flags", 32'({bus.rsp_c, bus.rsp_v, bus.rsp_z, bus.rsp_n}), 32'd0);
    check("reset_alu_idle",
          32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c_in, bus.alu_dec_add, bus.alu_dec_sub}),
          32'({8'h00, 8'h00, OP_ORA, 3'b000}));
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].da, vecs[i].ds,
             vecs[i].word, res, cvzn, lat);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("vec%0d_flags_cvzn", i), 32'(cvzn), 32'(vecs[i].cvzn));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Carry chaining on word ADC: 0xFF+0x01 low byte carries into high pass.
    run_op(OP_ADC, 16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, res, cvzn, lat);
    check("adc_pass1_cin", 32'(cap_cin[0]), 32'd0);
    check("adc_pass2_cin", 32'(cap_cin[1]), 32'd1);
    check("adc_pass2_a", 32'(cap_a[1]), 32'h12);

    // Word ASR runs high byte first, low byte as SHR.
    run_op(OP_ASR, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, res, cvzn, lat);
    check("asr_pass1_op", 32'(cap_op[0]), 32'(OP_ASR));
    check("asr_pass1_a", 32'(cap_a[0]), 32'h80);
    check("asr_pass2_op", 32'(cap_op[1]), 32'(OP_SHR));
    check("asr_pass2_a", 32'(cap_a[1]), 32'h01);
    check("asr_pass2_cin", 32'(cap_cin[1]), 32'd0);

    // Backpressure: a second request stays pending while the response waits.
    @(negedge clk);
    bus.req_op = OP_ADC; bus.req_a = 16'h1234; bus.req_b = 16'h1111; bus.req_c = 1'b0;
    bus.req_dec_add = 1'b0; bus.req_dec_sub = 1'b0; bus.req_word = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.req_a = 16'hFFFF; bus.req_b = 16'hFFFF;
    t = 0;
    while (!bus.rsp_valid && t < 8) begin @(posedge clk); @(negedge clk); t++; end
    check("bp_latency", 32'(t), 32'd2);
    snap  = bus.rsp_result;
    snapf = {bus.rsp_c, bus.rsp_v, bus.rsp_z, bus.rsp_n};
    check("bp_result", 32'(snap), 32'h2345);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_hold_result", 32'(bus.rsp_result), 32'(snap));
      check("bp_hold_flags", 32'({bus.rsp_c, bus.rsp_v, bus.rsp_z, bus.rsp_n}), 32'(snapf));
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_release_req_ready", 32'(bus.req_ready), 32'd1);

    // Reset during PASS2 aborts with no response.
    @(negedge clk);
    bus.req_op = OP_ADC; bus.req_a = 16'h0101; bus.req_b = 16'h0202; bus.req_word = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rel_req_ready", 32'(bus.req_ready), 32'd1);
    run_op(OP_SBC, 16'h1000, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, res, cvzn, lat);
    check("rst_first_result", 32'(res), 32'h0FFF);
    check("rst_first_flags", 32'(cvzn), 32'b1000);

    // Randomized binary operations against the word-level reference.
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(7, 0));
      a  = 16'($urandom);
      b  = 16'($urandom);
      c  = 1'($urandom);
      w  = 1'($urandom);
      ref_op(op, a, b, c, w, eres, ecvzn);
      run_op(op, a, b, c, 1'b0, 1'b0, w, res, cvzn, lat);
      check($sformatf("rand%0d_op%0d_w%0d_result", i, op, w), 32'(res), 32'(eres));
      check($sformatf("rand%0d_op%0d_w%0d_flags", i, op, w), 32'(cvzn), 32'(ecvzn));
      check($sformatf("rand%0d_latency", i), 32'(lat), w ? 32'd2 : 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
